// File: rtl/core_run_ctrl.sv
// core_run_ctrl: life-cycle sequencer for the single-cycle core.
// Owns the IDLE/LOAD/RUN/DONE/HANG life cycle. It gates PC advance and
// write enables, shares the data-memory port between the host loader and
// the core, counts RUN cycles, and flags programs that hang.
module core_run_ctrl #(
  parameter int          D       = 12,
  parameter int          DONE_PC = 250,
  parameter int          CW      = 16,
  parameter int unsigned MAX_CYC = 32'h0000_FFFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic [D-1:0]  prog_ctr,
  input  logic          ld_wr_en,
  input  logic [7:0]    ld_addr,
  input  logic [7:0]    ld_dat,
  input  logic          core_rd_en,
  input  logic          core_wr_en,
  input  logic [7:0]    core_addr,
  input  logic [7:0]    core_dat,
  output logic          mem_rd_en,
  output logic          mem_wr_en,
  output logic [7:0]    mem_addr,
  output logic [7:0]    mem_dat,
  output logic          pc_clr,
  output logic          core_en,
  output logic          done,
  output logic          timeout,
  output logic          ld_err,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE,
    S_HANG
  } state_t;

  // PC value that ends a program, and the last counter value before a hang.
  localparam logic [D-1:0]  DONE_PC_V = D'(DONE_PC);
  localparam logic [CW-1:0] HANG_AT   = CW'(MAX_CYC - 1);

  state_t state;
  state_t next_state;

  // State register; reset returns to IDLE from any state.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of the order of the always blocks.
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic. In RUN: abort, then completion, then the hang limit.
  always_comb begin
    // NOTE: default assigned first so no path leaves next_state unassigned,
    // which would otherwise infer a latch.
    next_state = state;
    unique case (state)
      S_IDLE: if (init) next_state = S_LOAD;
      S_LOAD: if (!init) next_state = S_RUN;
      S_RUN: begin
        if (init)                       next_state = S_LOAD;
        else if (prog_ctr == DONE_PC_V) next_state = S_DONE;
        else if (cycle_cnt == HANG_AT)  next_state = S_HANG;
      end
      S_DONE, S_HANG: if (init) next_state = S_LOAD;
      default: next_state = S_IDLE;
    endcase
  end

  // RUN cycle counter: cleared on entry to LOAD, saturates, and holds elsewhere.
  always_ff @(posedge clk) begin
    if (reset)
      cycle_cnt <= '0;
    else if (next_state == S_LOAD)
      cycle_cnt <= '0;
    else if (state == S_RUN && cycle_cnt != '1)
      cycle_cnt <= cycle_cnt + 1'b1;
  end

  // Status flags. done and timeout are registered decodes of the next state.
  // ld_err latches a loader write seen outside LOAD, and only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      done    <= 1'b0;
      timeout <= 1'b0;
      ld_err  <= 1'b0;
    end else begin
      done    <= (next_state == S_DONE);
      timeout <= (next_state == S_HANG);
      ld_err  <= ld_err | (ld_wr_en && state != S_LOAD);
    end
  end

  // Core gating and memory-port mux. Reset kills any in-flight access at once.
  always_comb begin
    pc_clr    = 1'b0;
    core_en   = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = '0;
    mem_dat   = '0;
    if (reset) begin
      pc_clr = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: pc_clr = 1'b1;
        S_LOAD: begin
          pc_clr    = 1'b1;
          mem_wr_en = ld_wr_en;
          mem_addr  = ld_addr;
          mem_dat   = ld_dat;
        end
        S_RUN: begin
          core_en   = 1'b1;
          mem_rd_en = core_rd_en;
          mem_wr_en = core_wr_en;
          mem_addr  = core_addr;
          mem_dat   = core_dat;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl. A vector table covers IDLE/LOAD/RUN entry.
// Hand-written sequences cover completion, ld_err, the hang limit (second
// instance with a small MAX_CYC), abort, and reset during RUN/DONE. Memory
// writes are checked through an expected-write queue.
module tb_core_run_ctrl;

  logic        clk = 1'b0;
  logic        reset, init;
  logic [11:0] prog_ctr;
  logic        ld_wr_en, core_rd_en, core_wr_en;
  logic [7:0]  ld_addr, ld_dat, core_addr, core_dat;

  logic        mem_rd_en, mem_wr_en, pc_clr, core_en, done, timeout, ld_err;
  logic [7:0]  mem_addr, mem_dat;
  logic [15:0] cycle_cnt;

  logic        h_mem_rd_en, h_mem_wr_en, h_pc_clr, h_core_en, h_done, h_timeout, h_ld_err;
  logic [7:0]  h_mem_addr, h_mem_dat;
  logic [15:0] h_cycle_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  logic [15:0] sb_q[$];

  always #5 clk = ~clk;

  core_run_ctrl dut (
    .clk(clk), .reset(reset), .init(init), .prog_ctr(prog_ctr),
    .ld_wr_en(ld_wr_en), .ld_addr(ld_addr), .ld_dat(ld_dat),
    .core_rd_en(core_rd_en), .core_wr_en(core_wr_en),
    .core_addr(core_addr), .core_dat(core_dat),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_dat(mem_dat),
    .pc_clr(pc_clr), .core_en(core_en), .done(done), .timeout(timeout),
    .ld_err(ld_err), .cycle_cnt(cycle_cnt)
  );

  core_run_ctrl #(.MAX_CYC(16)) dut_h (
    .clk(clk), .reset(reset), .init(init), .prog_ctr(prog_ctr),
    .ld_wr_en(ld_wr_en), .ld_addr(ld_addr), .ld_dat(ld_dat),
    .core_rd_en(core_rd_en), .core_wr_en(core_wr_en),
    .core_addr(core_addr), .core_dat(core_dat),
    .mem_rd_en(h_mem_rd_en), .mem_wr_en(h_mem_wr_en), .mem_addr(h_mem_addr), .mem_dat(h_mem_dat),
    .pc_clr(h_pc_clr), .core_en(h_core_en), .done(h_done), .timeout(h_timeout),
    .ld_err(h_ld_err), .cycle_cnt(h_cycle_cnt)
  );

  typedef struct {
    logic       init, ld_wr_en;
    logic [7:0] ld_addr, ld_dat;
    logic       core_rd_en, core_wr_en;
    logic [7:0] core_addr, core_dat;
    logic [11:0] prog_ctr;
    logic       e_rd, e_wr;
    logic [7:0] e_addr, e_dat;
    logic       e_pc_clr, e_core_en;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_core();
    core_rd_en = 1'b0; core_wr_en = 1'b0; core_addr = 8'h00; core_dat = 8'h00;
    ld_wr_en = 1'b0; ld_addr = 8'h00; ld_dat = 8'h00;
  endtask

  // Scoreboard: every memory write the default instance issues must match the
  // oldest expected write.
  always @(negedge clk) begin
    if (mem_wr_en) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_unexpected_wr: got addr 'h%0h dat 'h%0h, expected no write (t=%0t)",
                 mem_addr, mem_dat, $time);
      end else begin
        check("sb_wr", {mem_addr, mem_dat}, sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    // Table: IDLE with init seen, four loader writes (core junk ignored),
    // LOAD with init dropped, then two RUN cycles driven by the core.
    vecs[0] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 12'd0,
                1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++)
      vecs[1+i] = '{1'b1, 1'b1, 8'(i), 8'(8'hA0 + i), 1'b1, 1'b1, 8'hEE, 8'hEE, 12'd0,
                    1'b0, 1'b1, 8'(i), 8'(8'hA0 + i), 1'b1, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h33, 8'h44, 12'd0,
                1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h10, 8'h55, 12'd0,
                1'b0, 1'b1, 8'h10, 8'h55, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h22, 8'h00, 12'd1,
                1'b1, 1'b0, 8'h22, 8'h00, 1'b0, 1'b1};

    reset = 1'b1; init = 1'b0; prog_ctr = '0;
    clear_core();
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_pc_clr", pc_clr, 1);
    check("rst_core_en", core_en, 0);
    check("rst_done", done, 0);
    check("rst_timeout", timeout, 0);
    check("rst_ld_err", ld_err, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_mem", {mem_rd_en, mem_wr_en, mem_addr, mem_dat}, 0);

    foreach (vecs[i]) begin
      tick();
      init = vecs[i].init; ld_wr_en = vecs[i].ld_wr_en;
      ld_addr = vecs[i].ld_addr; ld_dat = vecs[i].ld_dat;
      core_rd_en = vecs[i].core_rd_en; core_wr_en = vecs[i].core_wr_en;
      core_addr = vecs[i].core_addr; core_dat = vecs[i].core_dat;
      prog_ctr = vecs[i].prog_ctr;
      if (vecs[i].e_wr) sb_q.push_back({vecs[i].e_addr, vecs[i].e_dat});
      @(negedge clk);
      check($sformatf("v%0d_mem_rd_en", i), mem_rd_en, vecs[i].e_rd);
      check($sformatf("v%0d_mem_wr_en", i), mem_wr_en, vecs[i].e_wr);
      check($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
      check($sformatf("v%0d_mem_dat", i), mem_dat, vecs[i].e_dat);
      check($sformatf("v%0d_pc_clr", i), pc_clr, vecs[i].e_pc_clr);
      check($sformatf("v%0d_core_en", i), core_en, vecs[i].e_core_en);
      check($sformatf("v%0d_ld_err", i), ld_err, 0);
    end

    // Continue RUN up to the completion PC; a loader write mid-RUN flags ld_err.
    for (int pc = 2; pc <= 250; pc++) begin
      tick();
      clear_core();
      prog_ctr = 12'(pc);
      if (pc == 100) begin
        ld_wr_en = 1'b1; ld_addr = 8'h77; ld_dat = 8'h99;
        core_wr_en = 1'b1; core_addr = 8'h10; core_dat = 8'h5A;
        sb_q.push_back(16'h105A);
      end
      @(negedge clk);
      if (pc == 100) begin
        check("run_ld_addr_blocked", mem_addr, 8'h10);
        check("run_ld_dat_blocked", mem_dat, 8'h5A);
        check("run_ld_err_not_yet", ld_err, 0);
      end
      if (pc == 101) check("run_ld_err_set", ld_err, 1);
      if (pc == 250) begin
        check("run_done_not_yet", done, 0);
        check("run_cnt_at_250", cycle_cnt, 250);
      end
    end

    tick();
    prog_ctr = '0;
    core_wr_en = 1'b1; core_addr = 8'h5C; core_dat = 8'h5D;
    @(negedge clk);
    check("done_done", done, 1);
    check("done_cycle_cnt", cycle_cnt, 251);
    check("done_core_en", core_en, 0);
    check("done_pc_clr", pc_clr, 0);
    check("done_mem_idle", {mem_wr_en, mem_addr, mem_dat}, 0);
    repeat (3) tick();
    clear_core();
    @(negedge clk);
    check("done_cnt_held", cycle_cnt, 251);
    check("done_held", done, 1);
    check("done_ld_err_sticky", ld_err, 1);
    check("done_timeout", timeout, 0);

    // Reset while in DONE.
    tick(); reset = 1'b1;
    tick(); reset = 1'b0;
    @(negedge clk);
    check("rdone_done", done, 0);
    check("rdone_cycle_cnt", cycle_cnt, 0);
    check("rdone_ld_err", ld_err, 0);
    check("rdone_pc_clr", pc_clr, 1);
    check("rdone_core_en", core_en, 0);

    // Hang on the MAX_CYC=16 instance with the PC stuck at 5.
    tick(); init = 1'b1;
    tick(); init = 1'b0;
    tick(); prog_ctr = 12'd5;
    repeat (15) tick();
    @(negedge clk);
    check("hang_pre_timeout", h_timeout, 0);
    check("hang_pre_cnt", h_cycle_cnt, 15);
    check("hang_pre_core_en", h_core_en, 1);
    tick();
    @(negedge clk);
    check("hang_timeout", h_timeout, 1);
    check("hang_done", h_done, 0);
    check("hang_cnt", h_cycle_cnt, 16);
    check("hang_core_en", h_core_en, 0);
    check("hang_default_no_timeout", timeout, 0);
    tick();
    @(negedge clk);
    check("hang_cnt_held", h_cycle_cnt, 16);
    check("hang_timeout_held", h_timeout, 1);

    // Abort with init at RUN cycle 7, then a fresh RUN from PC 0.
    tick(); init = 1'b1;
    tick(); init = 1'b0;
    tick(); prog_ctr = 12'd0;
    for (int c = 2; c <= 7; c++) begin
      tick();
      prog_ctr = 12'(c - 1);
    end
    init = 1'b1;
    @(negedge clk);
    check("abort_cnt_before", cycle_cnt, 6);
    check("abort_core_en_before", core_en, 1);
    tick(); init = 1'b0;
    @(negedge clk);
    check("abort_pc_clr", pc_clr, 1);
    check("abort_core_en", core_en, 0);
    check("abort_cnt_cleared", cycle_cnt, 0);
    check("abort_done", done, 0);
    tick(); prog_ctr = 12'd0;
    @(negedge clk);
    check("rerun_core_en", core_en, 1);
    check("rerun_pc_clr", pc_clr, 0);
    check("rerun_cnt", cycle_cnt, 0);
    tick(); prog_ctr = 12'd1;
    @(negedge clk);
    check("rerun_cnt_inc", cycle_cnt, 1);

    // Reset during RUN with a store in flight: the store must not reach memory.
    tick();
    reset = 1'b1;
    core_wr_en = 1'b1; core_addr = 8'h44; core_dat = 8'h66;
    @(negedge clk);
    check("rrun_mem_wr_en", mem_wr_en, 0);
    check("rrun_core_en", core_en, 0);
    tick();
    reset = 1'b0;
    clear_core();
    @(negedge clk);
    check("rrun_pc_clr", pc_clr, 1);
    check("rrun_cnt", cycle_cnt, 0);

    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
